// File: rtl/fifo_to_mig_axi_if.sv
// AXI4 bundle between the FIFO bridge (master) and the DDR3 controller slave port.
interface fifo_to_mig_axi_if;
    logic [3:0]   awid;
    logic [27:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awlock;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic [3:0]   awqos;
    logic         awvalid;
    logic         awready;

    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;

    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    logic [3:0]   arid;
    logic [27:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic [3:0]   arqos;
    logic         arvalid;
    logic         arready;

    logic [3:0]   rid;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/fifo_to_mig_axi.sv
// Drains a write FIFO into DDR3 and refills a read FIFO from DDR3 with fixed-length
// AXI4 bursts over two circular address windows; one burst in flight at a time.
module fifo_to_mig_axi #(
    parameter int unsigned WR_DDR_ADDR_BEGIN = 0,
    parameter int unsigned WR_DDR_ADDR_END   = 2048,
    parameter int unsigned RD_DDR_ADDR_BEGIN = 0,
    parameter int unsigned RD_DDR_ADDR_END   = 2048,
    parameter logic [3:0]  AXI_ID            = 4'b0000,
    parameter logic [7:0]  AXI_LEN           = 8'd31,
    parameter int unsigned RD_FIFO_DEPTH     = 64
) (
    input  logic         ui_clk,
    input  logic         ui_clk_sync_rst,
    input  logic         mmcm_locked,
    input  logic         init_calib_complete,

    input  logic         wr_addr_clr,
    output logic         wr_fifo_rdreq,
    input  logic [127:0] wr_fifo_rddata,
    input  logic         wr_fifo_empty,
    input  logic [8:0]   wr_fifo_rd_cnt,
    input  logic         wr_fifo_rst_busy,

    input  logic         rd_addr_clr,
    output logic         rd_fifo_wrreq,
    output logic [127:0] rd_fifo_wrdata,
    input  logic         rd_fifo_alfull,
    input  logic [8:0]   rd_fifo_wr_cnt,
    input  logic         rd_fifo_rst_busy,

    fifo_to_mig_axi_if.master m_axi
);

    localparam int unsigned BEATS    = int'(AXI_LEN) + 1;
    localparam logic [27:0] STEP     = 28'(BEATS * 16);
    localparam logic [27:0] WR_BEGIN = 28'(WR_DDR_ADDR_BEGIN);
    localparam logic [27:0] RD_BEGIN = 28'(RD_DDR_ADDR_BEGIN);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t      state, state_next;
    logic        last_wr;
    logic        awvalid_q, arvalid_q;
    logic [27:0] awaddr_q, araddr_q;
    logic [27:0] wr_addr, rd_addr;
    logic [27:0] wr_addr_inc, rd_addr_inc, wr_addr_next, rd_addr_next;
    logic [7:0]  beat_cnt;
    logic        ready, wr_req, rd_req;
    logic        w_fire, wr_done, rd_done;

    assign ready  = mmcm_locked & init_calib_complete;
    assign wr_req = ready && !wr_addr_clr && !wr_fifo_rst_busy &&
                    (32'(wr_fifo_rd_cnt) >= BEATS);
    assign rd_req = ready && !rd_addr_clr && !rd_fifo_rst_busy && !rd_fifo_alfull &&
                    (32'(rd_fifo_wr_cnt) + BEATS <= RD_FIFO_DEPTH);

    assign w_fire  = (state == WR_DATA) && !wr_fifo_empty && m_axi.wready;
    assign wr_done = (state == WR_RESP) && m_axi.bvalid;
    assign rd_done = (state == RD_DATA) && m_axi.rvalid && m_axi.rlast;

    // 28-bit wrap-around sum, then fold back into the window at or past its end
    assign wr_addr_inc  = wr_addr + STEP;
    assign rd_addr_inc  = rd_addr + STEP;
    assign wr_addr_next = (32'(wr_addr_inc) >= WR_DDR_ADDR_END) ? WR_BEGIN : wr_addr_inc;
    assign rd_addr_next = (32'(rd_addr_inc) >= RD_DDR_ADDR_END) ? RD_BEGIN : rd_addr_inc;

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        // NOTE: state elements use non-blocking assignments so every register samples
        // pre-edge values, independent of the order the always blocks are evaluated in.
        if (ui_clk_sync_rst) state <= IDLE;
        else                 state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path through the
        // case statement leaves a signal unassigned and no latch is inferred.
        state_next     = state;
        m_axi.wvalid   = 1'b0;
        m_axi.wlast    = 1'b0;
        m_axi.bready   = 1'b0;
        m_axi.rready   = 1'b0;
        wr_fifo_rdreq  = 1'b0;
        rd_fifo_wrreq  = 1'b0;
        rd_fifo_wrdata = '0;
        case (state)
            IDLE: begin
                // Round-robin: a pending read wins only if write was served last.
                if (wr_req && (!rd_req || !last_wr)) state_next = WR_ADDR;
                else if (rd_req)                     state_next = RD_ADDR;
            end
            WR_ADDR: if (awvalid_q && m_axi.awready) state_next = WR_DATA;
            WR_DATA: begin
                m_axi.wvalid  = !wr_fifo_empty;
                m_axi.wlast   = (beat_cnt == AXI_LEN);
                wr_fifo_rdreq = w_fire;
                if (w_fire && beat_cnt == AXI_LEN) state_next = WR_RESP;
            end
            WR_RESP: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) state_next = IDLE;
            end
            RD_ADDR: if (arvalid_q && m_axi.arready) state_next = RD_DATA;
            RD_DATA: begin
                m_axi.rready   = 1'b1;
                rd_fifo_wrreq  = m_axi.rvalid;
                rd_fifo_wrdata = m_axi.rdata;
                if (m_axi.rvalid && m_axi.rlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            last_wr   <= 1'b0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            awaddr_q  <= WR_BEGIN;
            araddr_q  <= RD_BEGIN;
            wr_addr   <= WR_BEGIN;
            rd_addr   <= RD_BEGIN;
            beat_cnt  <= '0;
        end else begin
            if (state == IDLE && state_next == WR_ADDR) begin
                last_wr   <= 1'b1;
                awvalid_q <= 1'b1;
                awaddr_q  <= wr_addr;
            end else if (awvalid_q && m_axi.awready) begin
                awvalid_q <= 1'b0;
            end

            if (state == IDLE && state_next == RD_ADDR) begin
                last_wr   <= 1'b0;
                arvalid_q <= 1'b1;
                araddr_q  <= rd_addr;
            end else if (arvalid_q && m_axi.arready) begin
                arvalid_q <= 1'b0;
            end

            if (state == WR_ADDR) beat_cnt <= '0;
            else if (w_fire)      beat_cnt <= beat_cnt + 8'd1;

            // A held clear pins the window start and swallows the end-of-burst step.
            if (wr_addr_clr)  wr_addr <= WR_BEGIN;
            else if (wr_done) wr_addr <= wr_addr_next;

            if (rd_addr_clr)  rd_addr <= RD_BEGIN;
            else if (rd_done) rd_addr <= rd_addr_next;
        end
    end

    assign m_axi.awid    = AXI_ID;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awlen   = AXI_LEN;
    assign m_axi.awsize  = 3'b100;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0010;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awqos   = 4'b0000;
    assign m_axi.awvalid = awvalid_q;

    assign m_axi.wdata   = wr_fifo_rddata;
    assign m_axi.wstrb   = 16'hFFFF;

    assign m_axi.arid    = AXI_ID;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = AXI_LEN;
    assign m_axi.arsize  = 3'b100;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0010;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arqos   = 4'b0000;
    assign m_axi.arvalid = arvalid_q;

endmodule

// File: tb/tb_fifo_to_mig_axi.sv
// Randomized bench: FIFO models and an AXI slave with a sparse DDR image, checked
// against burst-level address/data expectations derived from the window rules.
module tb_fifo_to_mig_axi;
  localparam int BEATS = 32;
  localparam int STEP = 512;
  localparam int WIN = 2048;
  localparam int DEPTH = 64;
  localparam int ALFULL_AT = 62;
  localparam logic [32:0] AX_FIELDS = {4'h0, 8'd31, 3'b100, 2'b01, 1'b0, 4'b0010, 3'b000, 4'h0};

  logic ui_clk = 1'b0;
  logic ui_clk_sync_rst = 1'b1;
  logic mmcm_locked = 1'b0, init_calib_complete = 1'b0;
  logic wr_addr_clr = 1'b0, rd_addr_clr = 1'b0;
  logic wr_fifo_rdreq, rd_fifo_wrreq;
  logic [127:0] wr_fifo_rddata = '0, rd_fifo_wrdata;
  logic wr_fifo_empty = 1'b1, wr_fifo_rst_busy = 1'b0;
  logic [8:0] wr_fifo_rd_cnt = '0, rd_fifo_wr_cnt = '0;
  logic rd_fifo_alfull = 1'b0, rd_fifo_rst_busy = 1'b0;

  fifo_to_mig_axi_if axi();

  fifo_to_mig_axi dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst),
    .mmcm_locked(mmcm_locked), .init_calib_complete(init_calib_complete),
    .wr_addr_clr(wr_addr_clr), .wr_fifo_rdreq(wr_fifo_rdreq), .wr_fifo_rddata(wr_fifo_rddata),
    .wr_fifo_empty(wr_fifo_empty), .wr_fifo_rd_cnt(wr_fifo_rd_cnt), .wr_fifo_rst_busy(wr_fifo_rst_busy),
    .rd_addr_clr(rd_addr_clr), .rd_fifo_wrreq(rd_fifo_wrreq), .rd_fifo_wrdata(rd_fifo_wrdata),
    .rd_fifo_alfull(rd_fifo_alfull), .rd_fifo_wr_cnt(rd_fifo_wr_cnt), .rd_fifo_rst_busy(rd_fifo_rst_busy),
    .m_axi(axi)
  );

  always #5 ui_clk = ~ui_clk;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: FIFO contents, DDR image keyed by 16-byte word index, window pointers.
  logic [127:0] wq[$];
  logic [127:0] rq[$];
  logic [127:0] mem[int];
  int exp_wr = 0, exp_rd = 0;
  int aw_cnt = 0, ar_cnt = 0, wr_done = 0, rd_done = 0;
  int kinds[$];
  int ar_log[$];
  int last_awaddr = -1;
  bit w_active = 0, b_pend = 0, r_active = 0, rd_drain = 0;
  int w_beat = 0, w_addr = 0, rdreq_cnt = 0, b_wait = 0, r_beat = 0, r_addr = 0;
  logic prev_awvalid = 0, prev_awready = 0, prev_arvalid = 0, prev_arready = 0;
  logic [27:0] prev_awaddr = '0, prev_araddr = '0;

  function automatic int next_addr(input int a);
    return (a + STEP >= WIN) ? 0 : a + STEP;
  endfunction

  function automatic logic [127:0] mem_rd(input int widx);
    if (mem.exists(widx)) return mem[widx];
    return {4{32'(widx) ^ 32'hA5A5_0000}};
  endfunction

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic sample();
    if (prev_awvalid && !prev_awready) begin
      check("aw_hold_valid", axi.awvalid, 1'b1);
      check("aw_hold_addr", axi.awaddr, prev_awaddr);
    end
    if (prev_arvalid && !prev_arready) begin
      check("ar_hold_valid", axi.arvalid, 1'b1);
      check("ar_hold_addr", axi.araddr, prev_araddr);
    end
    prev_awvalid = axi.awvalid; prev_awready = axi.awready; prev_awaddr = axi.awaddr;
    prev_arvalid = axi.arvalid; prev_arready = axi.arready; prev_araddr = axi.araddr;

    if (axi.bready || b_pend) check("bready", axi.bready, b_pend);
    if (axi.rready || r_active) check("rready", axi.rready, r_active);
    if (b_pend && b_wait > 0) b_wait--;

    if (axi.awvalid && axi.awready) begin
      check("awaddr", axi.awaddr, 128'(exp_wr));
      check("aw_fields", {axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.awlock,
                          axi.awcache, axi.awprot, axi.awqos}, AX_FIELDS);
      check("aw_fifo_level", wq.size() >= BEATS, 1'b1);
      check("aw_overlap", w_active || b_pend || r_active, 1'b0);
      aw_cnt++; kinds.push_back(0); last_awaddr = int'(axi.awaddr);
      w_active = 1; w_beat = 0; w_addr = int'(axi.awaddr); rdreq_cnt = 0;
    end

    if (axi.wvalid || wr_fifo_rdreq) check("rdreq_strobe", wr_fifo_rdreq, axi.wvalid && axi.wready);
    if (axi.wvalid && axi.wready) begin
      check("w_in_burst", w_active, 1'b1);
      check("wvalid_nonempty", wq.size() > 0, 1'b1);
      check("wdata", axi.wdata, (wq.size() > 0) ? wq[0] : 128'h0);
      check("wstrb", axi.wstrb, 16'hFFFF);
      check("wlast", axi.wlast, w_beat == BEATS - 1);
      mem[w_addr / 16 + w_beat] = axi.wdata;
      w_beat++;
      if (w_beat == BEATS) begin
        w_active = 0; b_pend = 1; b_wait = $urandom_range(0, 3);
      end
    end
    if (wr_fifo_rdreq) begin
      rdreq_cnt++;
      if (wq.size() > 0) void'(wq.pop_front());
    end

    if (axi.bvalid && axi.bready) begin
      check("w_beats", w_beat, BEATS);
      check("rdreq_count", rdreq_cnt, BEATS);
      b_pend = 0; wr_done++;
      if (!wr_addr_clr) exp_wr = next_addr(exp_wr);
    end
    if (wr_addr_clr) exp_wr = 0;

    if (rd_fifo_wrreq || (axi.rvalid && axi.rready))
      check("wrreq_strobe", rd_fifo_wrreq, axi.rvalid && axi.rready);
    if (axi.rvalid && axi.rready) begin
      check("rd_data", rd_fifo_wrdata, mem_rd(r_addr / 16 + r_beat));
      rq.push_back(rd_fifo_wrdata);
      r_beat++;
      if (r_beat == BEATS) begin
        r_active = 0; rd_done++;
        if (!rd_addr_clr) exp_rd = next_addr(exp_rd);
      end
    end
    if (rd_addr_clr) exp_rd = 0;

    if (axi.arvalid && axi.arready) begin
      check("araddr", axi.araddr, 128'(exp_rd));
      check("ar_fields", {axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arlock,
                          axi.arcache, axi.arprot, axi.arqos}, AX_FIELDS);
      check("ar_room", rq.size() + BEATS <= DEPTH, 1'b1);
      check("ar_overlap", w_active || b_pend || r_active, 1'b0);
      ar_cnt++; kinds.push_back(1); ar_log.push_back(int'(axi.araddr));
      r_active = 1; r_beat = 0; r_addr = int'(axi.araddr);
    end

    if (rd_drain && rq.size() > 0 && $urandom_range(0, 1) != 0) void'(rq.pop_front());
  endtask

  // Slave and FIFO-flag driver: drive on the falling edge, evaluate handshakes 1 ns later.
  initial begin
    forever begin
      @(negedge ui_clk);
      wr_fifo_empty  = (wq.size() == 0);
      wr_fifo_rddata = (wq.size() > 0) ? wq[0] : 128'h0;
      wr_fifo_rd_cnt = 9'((wq.size() > 511) ? 511 : wq.size());
      rd_fifo_wr_cnt = 9'(rq.size());
      rd_fifo_alfull = (rq.size() >= ALFULL_AT);
      axi.awready = ($urandom_range(0, 3) != 0);
      axi.wready  = ($urandom_range(0, 3) != 0);
      axi.arready = ($urandom_range(0, 3) != 0);
      axi.bid     = 4'h0;
      axi.bresp   = 2'($urandom);
      axi.bvalid  = b_pend && (b_wait == 0);
      axi.rid     = 4'h0;
      axi.rresp   = 2'b00;
      axi.rvalid  = r_active && ($urandom_range(0, 3) != 0);
      axi.rdata   = r_active ? mem_rd(r_addr / 16 + r_beat) : 128'h0;
      axi.rlast   = r_active && (r_beat == BEATS - 1);
      #1;
      sample();
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge ui_clk);
    #2;
  endtask

  task automatic wait_done(input int wt, input int rt, input string tag);
    for (int i = 0; i < 4000 && !(wr_done >= wt && rd_done >= rt); i++) cycles(1);
    check(tag, (wr_done >= wt) && (rd_done >= rt), 1'b1);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) wq.push_back(rand_word());
  endtask

  initial begin
    int base, quiet, prev_rd;
    axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.bvalid = 0; axi.rvalid = 0;
    axi.rlast = 0; axi.rdata = '0; axi.bid = '0; axi.bresp = '0; axi.rid = '0; axi.rresp = '0;

    cycles(3);
    check("rst_awvalid", axi.awvalid, 1'b0);
    check("rst_wvalid", axi.wvalid, 1'b0);
    check("rst_wlast", axi.wlast, 1'b0);
    check("rst_bready", axi.bready, 1'b0);
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_rready", axi.rready, 1'b0);
    check("rst_rdreq", wr_fifo_rdreq, 1'b0);
    check("rst_wrreq", rd_fifo_wrreq, 1'b0);
    check("rst_awaddr", axi.awaddr, 28'd0);
    check("rst_araddr", axi.araddr, 28'd0);
    check("rst_wrdata", rd_fifo_wrdata, 128'h0);

    // Both requests pending from the first ready cycle: expect W, R, W, R.
    push_words(64);
    ui_clk_sync_rst = 1'b0;
    cycles(10);
    check("no_burst_unlocked", aw_cnt + ar_cnt, 0);
    mmcm_locked = 1'b1;
    cycles(5);
    check("no_burst_uncalib", aw_cnt + ar_cnt, 0);
    init_calib_complete = 1'b1;
    wait_done(2, 2, "arb_bursts");
    for (int i = 0; i < 4; i++)
      check($sformatf("arb_order%0d", i), (kinds.size() > i) ? kinds[i] : 2, i % 2);

    // Write throttle at 31 words, then one more word releases a burst.
    cycles(5);
    base = aw_cnt;
    push_words(31);
    cycles(40);
    check("throttle_31", aw_cnt, base);
    push_words(1);
    wait_done(wr_done + 1, 0, "throttle_32_done");
    check("throttle_32", aw_cnt, base + 1);

    // Stream 128 words with gaps; the write window wraps past 2048.
    base = wr_done + 4;
    for (int i = 0; i < 128; i++) begin
      push_words(1);
      cycles($urandom_range(0, 2));
    end
    wait_done(base, 0, "stream_done");
    check("wq_drained", wq.size(), 0);

    // Read side: clear pointer, empty FIFO -> bursts at 0 then 512.
    rd_addr_clr = 1'b1;
    cycles(3);
    rd_addr_clr = 1'b0;
    rq.delete();
    wait_done(0, rd_done + 2, "rd_clr_done");
    check("rd_clr_addr0", (ar_log.size() >= 2) ? ar_log[ar_log.size() - 2] : -1, 0);
    check("rd_clr_addr1", (ar_log.size() >= 2) ? ar_log[ar_log.size() - 1] : -1, 512);
    cycles(5);
    for (int i = 0; i < 31 && rq.size() > 0; i++) void'(rq.pop_front());
    check("rq_at_33", rq.size(), 33);
    base = ar_cnt;
    cycles(50);
    check("rd_throttle_33", ar_cnt, base);

    // Random read streaming while the sink drains, then quiesce via FIFO reset-busy.
    prev_rd = rd_done;
    rd_drain = 1;
    cycles(400);
    rd_drain = 0;
    rd_fifo_rst_busy = 1'b1;
    quiet = 0;
    for (int i = 0; i < 600 && quiet < 10; i++) begin
      cycles(1);
      quiet = (r_active || axi.arvalid) ? 0 : quiet + 1;
    end
    check("rd_quiesce", quiet, 10);
    check("rd_stream", rd_done > prev_rd + 2, 1'b1);

    // Clear during write data: burst completes, next burst restarts at 0.
    push_words(32);
    for (int i = 0; i < 2000 && !(w_active && w_beat >= 4); i++) cycles(1);
    check("clr_mid_burst_seen", w_active && w_beat >= 4, 1'b1);
    wr_addr_clr = 1'b1;
    wait_done(wr_done + 1, 0, "clr_burst_done");
    wr_addr_clr = 1'b0;
    push_words(32);
    wait_done(wr_done + 1, 0, "after_clr_done");
    check("clr_next_awaddr", last_awaddr, 0);

    cycles(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/fifo_to_mig_axi.md
# fifo_to_mig_axi

Bridge between two user-side FIFOs and the AXI4 slave port of the DDR3 memory controller, all in the controller's `ui_clk` domain. It drains a write FIFO into DDR3 as fixed-length AXI write bursts over a circular byte-address window. It also fills a read FIFO from a second circular window with fixed-length AXI read bursts whenever that FIFO has room. Typical use is a frame buffer between a pixel source/sink and the memory controller.

## Interface
Parameters:
- `WR_DDR_ADDR_BEGIN`, default 0: first byte address of the write window.
- `WR_DDR_ADDR_END`, default 2048: write window end, exclusive.
- `RD_DDR_ADDR_BEGIN`, default 0: first byte address of the read window.
- `RD_DDR_ADDR_END`, default 2048: read window end, exclusive.
- `AXI_ID`, default 4'b0000: value driven on awid/arid.
- `AXI_LEN`, default 8'd31: awlen/arlen value; burst is AXI_LEN+1 beats.
- `RD_FIFO_DEPTH`, default 64: read FIFO depth in 128-bit words.

Ports (one clock; reset is asynchronous and active-high):
- `ui_clk` in 1: sole clock.
- `ui_clk_sync_rst` in 1: asynchronous active-high reset.
- `mmcm_locked`, `init_calib_complete` in 1 each: controller ready qualifiers.
- `wr_addr_clr` in 1: level, resets write address to WR_DDR_ADDR_BEGIN.
- `wr_fifo_rdreq` out 1: read strobe to the write FIFO (FWFT).
- `wr_fifo_rddata` in 128: write FIFO head word.
- `wr_fifo_empty` in 1: write FIFO empty flag.
- `wr_fifo_rd_cnt` in 9: number of words in the write FIFO.
- `wr_fifo_rst_busy` in 1: write FIFO is in reset.
- `rd_addr_clr` in 1: level, resets read address to RD_DDR_ADDR_BEGIN.
- `rd_fifo_wrreq` out 1: write strobe to the read FIFO.
- `rd_fifo_wrdata` out 128: data written to the read FIFO.
- `rd_fifo_alfull` in 1: read FIFO almost-full flag.
- `rd_fifo_wr_cnt` in 9: number of words in the read FIFO.
- `rd_fifo_rst_busy` in 1: read FIFO is in reset.
- AW channel, out: `m_axi_awid` 4, `awaddr` 28, `awlen` 8, `awsize` 3, `awburst` 2, `awlock` 1, `awcache` 4, `awprot` 3, `awqos` 4, `awvalid` 1. In: `awready` 1.
- W channel, out: `m_axi_wdata` 128, `wstrb` 16, `wlast` 1, `wvalid` 1. In: `wready` 1.
- B channel, in: `m_axi_bid` 4, `bresp` 2, `bvalid` 1. Out: `bready` 1.
- AR channel, out: `m_axi_arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arlock`, `arcache`, `arprot`, `arqos`, `arvalid`, with the same widths as AW. In: `arready` 1.
- R channel, in: `m_axi_rid` 4, `rdata` 128, `rresp` 2, `rlast` 1, `rvalid` 1. Out: `rready` 1.

## Operation
- Constant AXI fields:
  - id = AXI_ID, len = AXI_LEN, size = 3'b100 (16 B), burst = INCR (2'b01).
  - lock = 0, cache = 4'b0010, prot = 0, qos = 0, wstrb = 16'hFFFF.
- One FSM with states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- `ready` is defined as mmcm_locked & init_calib_complete.
- Write request: ready & !wr_addr_clr & !wr_fifo_rst_busy & wr_fifo_rd_cnt >= AXI_LEN+1.
- Read request: ready & !rd_addr_clr & !rd_fifo_rst_busy & !rd_fifo_alfull & rd_fifo_wr_cnt + AXI_LEN+1 <= RD_FIFO_DEPTH.
- IDLE arbitration when both requests are pending: round-robin; the side not served last goes first. After reset, write goes first.
- IDLE → WR_ADDR or RD_ADDR.
- WR_ADDR: awvalid held until awready, then → WR_DATA.
- WR_DATA:
  - wvalid = !wr_fifo_empty; wdata = wr_fifo_rddata.
  - wr_fifo_rdreq = wvalid & wready.
  - wlast on beat AXI_LEN (counting from 0).
  - On the last accepted beat → WR_RESP.
- WR_RESP: bready = 1; on bvalid → IDLE. bresp is ignored.
- RD_ADDR: arvalid held until arready, then → RD_DATA.
- RD_DATA:
  - rready = 1; rd_fifo_wrreq = rvalid & rready; rd_fifo_wrdata = rdata.
  - On rvalid & rlast → IDLE.
- Address update after each completed burst: addr += (AXI_LEN+1)*16. If the result is >= END, addr = BEGIN instead. Arithmetic is 28-bit.
- wr_addr_clr / rd_addr_clr high:
  - Address register is forced to BEGIN every cycle.
  - An in-flight burst always completes.
  - The end-of-burst increment is suppressed while the clear is high.

## Timing
- Reset (async) state: FSM in IDLE, both addresses at their BEGIN values, round-robin pointer set so write goes first.
- Reset values of outputs: awvalid, wvalid, wlast, bready, arvalid, rready, wr_fifo_rdreq and rd_fifo_wrreq all 0. awaddr/araddr = BEGIN. rd_fifo_wrdata = 0.
- awvalid/arvalid are registered: asserted one cycle after leaving IDLE, deasserted the cycle after the address handshake.
- AXI signals are stable while valid is high and ready is low.
- Write-data and read-data strobes are combinational from valid & ready, so one FIFO word moves per handshake.
- A burst cannot be re-issued until the previous one fully completes (B response or rlast); there is no outstanding-transaction overlap.

## Test plan
- Reset: assert ui_clk_sync_rst → all valids and strobes 0, awaddr = 0, araddr = 0.
- Write burst: 32 words in the write FIFO, calibration done → awaddr 0, awlen 31, awsize 4, awburst 1; 32 W beats with wlast only on the 32nd; bready until bvalid; wr_fifo_rdreq exactly 32 times.
- Write wrap: stream 128 words (1024 16-bit samples) → bursts at 0, 512, 1024, 1536; the next burst goes to 0.
- Write throttle: wr_fifo_rd_cnt = 31 → no awvalid. Raising the count to 32 → a burst starts.
- Read after clear:
  - Pulse rd_addr_clr, read FIFO empty → araddr 0 then 512.
  - At rd_fifo_wr_cnt = 33 no arvalid is issued; read data equals the written data.
- Clear mid-burst: assert wr_addr_clr during WR_DATA → the burst completes with 32 beats, and the next awaddr = 0.
